// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a word-addressed data memory for MIPS
// byte-addressed loads/stores (lb/lbu/lh/lhu/lw/sb/sh/sw). Big-endian lanes.
// One request in flight; sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (accepted when both high)
//   req_we/size/unsigned     op decode: store flag, size (00 b, 01 h, 10 w), zero-extend
//   req_addr/req_wdata       byte address, right-justified store data
//   resp_valid/rdata/err     one-cycle completion pulse, load result, error flag
//   mem_addr/rd_en/rd_data   word index, read strobe, read data (one cycle later)
//   mem_wr_en/wr_data        write strobe and word to write
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

  state_t          state, state_next;
  logic            accept;
  logic            req_err;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      off_q;
  logic [15:0]     wdata_q;
  logic            wr_q;
  logic [4:0]      byte_shift;
  logic [4:0]      half_shift;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic [DW-1:0]   load_val;
  logic [DW-1:0]   merge_val;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & (state == IDLE);

  // Reset has to suppress a write that is being presented in this very cycle.
  assign mem_wr_en = wr_q & ~rst;

  // Acceptance-time error decode.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) req_err = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                           state_next = RESP;
          else if (req_we && req_size == 2'b10)  state_next = WRITE;
          else                                   state_next = READ;
        end
      end
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Big-endian lane select: byte offset o sits at bit 8*(3-o); half at 16*(1-o[1]).
  always_comb begin
    byte_shift = {~off_q, 3'b000};
    half_shift = {~off_q[1], 4'b0000};
    byte_val   = 8'(mem_rd_data >> byte_shift);
    half_val   = 16'(mem_rd_data >> half_shift);
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
      2'b01:   load_val = uns_q ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
      default: load_val = mem_rd_data;
    endcase
    if (size_q == 2'b00)
      merge_val = (mem_rd_data & ~(32'h0000_00FF << byte_shift)) |
                  (32'(wdata_q[7:0]) << byte_shift);
    else
      merge_val = (mem_rd_data & ~(32'h0000_FFFF << half_shift)) |
                  (32'(wdata_q) << half_shift);
  end

  // Request fields latched at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= 16'h0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata[15:0];
    end
  end

  // Registered outputs, timed from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en   <= 1'b0;
      wr_q        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_rd_en  <= (state_next == READ);
      wr_q       <= (state_next == WRITE);
      resp_valid <= (state_next == RESP);
      resp_err   <= accept & req_err;
      resp_rdata <= (state == CAPTURE && !we_q) ? load_val : '0;
      if (accept) mem_addr <= {2'b00, req_addr[31:2]};
      if (accept && req_we && req_size == 2'b10 && !req_err)
        mem_wr_data <= req_wdata;
      else if (state == CAPTURE && we_q)
        mem_wr_data <= merge_val;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  // Small memory model plus strobe/response monitors.
  logic [31:0] mem [16];
  bit          mem_init;
  int          rd_cnt, wr_cnt, resp_cnt, acc_cnt, overlap;
  logic [31:0] rd_addr, wr_addr;

  always @(posedge clk) begin
    if (!mem_init) begin
      mem[5]   <= 32'h8899AABB;
      mem_init <= 1'b1;
    end
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr[3:0]];
      rd_cnt      <= rd_cnt + 1;
      rd_addr     <= mem_addr;
    end
    if (mem_wr_en) begin
      mem[mem_addr[3:0]] <= mem_wr_data;
      wr_cnt             <= wr_cnt + 1;
      wr_addr            <= mem_addr;
    end
    if (mem_rd_en && mem_wr_en) overlap <= overlap + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (req_valid && req_ready && !rst) acc_cnt <= acc_cnt + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
  endtask

  // Issue one request from IDLE and check latency, response, strobe counts.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_edges, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_rd, input int exp_wr);
    int edges;
    int r0, w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    set_req(we, size, uns, addr, wdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 1;
    while (!resp_valid && edges < 12) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(exp_edges));
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, " resp_valid after"}, 32'(resp_valid), 32'd0);
    check({tag, " resp_rdata after"}, resp_rdata, 32'd0);
    check({tag, " req_ready after"}, 32'(req_ready), 32'd1);
    check({tag, " rd strobes"}, 32'(rd_cnt - r0), 32'(exp_rd));
    check({tag, " wr strobes"}, 32'(wr_cnt - w0), 32'(exp_wr));
  endtask

  initial begin
    int w0, p0, a0, k1, acc, waited;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("reset mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wr_data", mem_wr_data, 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loads from word 5 = 0x8899AABB.
    run_req("lb 0x14", 1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 3, 32'hFFFFFF88, 1'b0, 1, 0);
    check("lb rd addr", rd_addr, 32'd5);
    run_req("lbu 0x17", 1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 3, 32'h000000BB, 1'b0, 1, 0);
    check("lbu rd addr", rd_addr, 32'd5);
    run_req("lh 0x16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 3, 32'hFFFFAABB, 1'b0, 1, 0);
    run_req("lhu 0x14", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 3, 32'h00008899, 1'b0, 1, 0);
    run_req("lw 0x14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 3, 32'h8899AABB, 1'b0, 1, 0);

    // Sub-word and word stores.
    run_req("sb 0x15", 1'b1, 2'b00, 1'b0, 32'h15, 32'h12345677, 4, 32'h0, 1'b0, 1, 1);
    check("sb merged word", mem[5], 32'h8877AABB);
    check("sb wr addr", wr_addr, 32'd5);
    run_req("sw 0x20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
    check("sw word", mem[8], 32'hDEADBEEF);
    check("sw wr addr", wr_addr, 32'd8);
    run_req("sh 0x20", 1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF0042, 4, 32'h0, 1'b0, 1, 1);
    check("sh merged word", mem[8], 32'h0042BEEF);

    // Error requests: direct to RESP, no strobes.
    run_req("err lh 0x15", 1'b0, 2'b01, 1'b0, 32'h15, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("err lw 0x16", 1'b0, 2'b10, 1'b0, 32'h16, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("err size 11", 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("err lw 0x1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("err sw 0x16", 1'b1, 2'b10, 1'b0, 32'h16, 32'h1, 1, 32'h0, 1'b1, 0, 0);

    // Reset during CAPTURE of a halfword store.
    w0 = wr_cnt;
    p0 = resp_cnt;
    set_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst capture req_ready", 32'(req_ready), 32'd1);
    check("rst capture resp_valid", 32'(resp_valid), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst capture wr strobes", 32'(wr_cnt - w0), 32'd0);
    check("rst capture responses", 32'(resp_cnt - p0), 32'd0);
    check("rst capture memory", mem[5], 32'h8877AABB);

    // Reset during the WRITE cycle of a byte store.
    w0 = wr_cnt;
    set_req(1'b1, 2'b00, 1'b0, 32'h14, 32'h00000055);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst write wr_en before", 32'(mem_wr_en), 32'd1);
    check("rst write merged data", mem_wr_data, 32'h5577AABB);
    rst = 1'b1;
    #1;
    check("rst write wr_en gated", 32'(mem_wr_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst write wr strobes", 32'(wr_cnt - w0), 32'd0);
    check("rst write memory", mem[5], 32'h8877AABB);

    // req_valid held across a busy load.
    a0  = acc_cnt;
    acc = 0;
    k1  = 0;
    set_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      logic pre;
      pre = req_ready;
      @(posedge clk); #1;
      if (pre) begin
        acc++;
        if (acc == 1) k1 = k;
        else begin
          check("held accept spacing", 32'(k - k1), 32'd4);
          req_valid = 1'b0;
          break;
        end
      end
    end
    req_valid = 1'b0;
    check("held accept count", 32'(acc), 32'd2);
    waited = 0;
    while (!resp_valid && waited < 12) begin
      @(posedge clk); #1;
      waited++;
    end
    check("held second rdata", resp_rdata, 32'h8877AABB);
    check("held second waited", 32'(waited), 32'd2);
    @(posedge clk); #1;
    check("held monitor accepts", 32'(acc_cnt - a0), 32'd2);
    check("no strobe overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
